// File: rtl/byte_serial_adder_seq.sv
// Multi-precision adder sequencer: feeds an external 8-bit ripple-carry adder one byte per
// cycle (LSB first) and assembles the W-bit sum, carry-out and signed overflow for a valid/ready result port.
module byte_serial_adder_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_s,
  input  logic                  add_cout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  overflow
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            overflow_q, overflow_d;
  logic [IW+2:0]   bit_off;

  assign bit_off     = {idx_q, 3'b000};
  assign start_ready = (state_q == IDLE) && !rst;
  assign res_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign overflow    = overflow_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    add_a      = 8'h00;
    add_b      = 8'h00;
    add_cin    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid && start_ready) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[bit_off +: 8];
        add_b   = b_q[bit_off +: 8];
        add_cin = carry_q;
        sum_d[bit_off +: 8] = add_s;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          // Sign bits of the top byte decide two's-complement overflow of the full word.
          idx_d      = '0;
          cout_d     = add_cout;
          overflow_d = (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
          state_d    = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_byte_serial_adder_seq.sv
// Bench for byte_serial_adder_seq: models RCA8bit combinationally and checks results
// against plain full-width arithmetic.
module tb_byte_serial_adder_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          cin = 1'b0;
  logic [7:0]    add_a, add_b, add_s;
  logic          add_cin, add_cout;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          cout, overflow;

  int errors = 0;
  int checks = 0;

  logic [7:0] obs_a [NBYTES];
  logic [7:0] obs_b [NBYTES];
  logic       obs_c [NBYTES];

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  byte_serial_adder_seq #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  // {overflow, cout, sum} from whole-word arithmetic
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit release_res, input string name);
    logic [W+1:0] exp;
    int n;
    n = 0;
    while (!start_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!start_ready) begin
      errors++;
      $display("FAIL %s start_ready timeout: got 0 want 1", name);
    end
    exp = ref_add(a, b, c);
    op_a = a; op_b = b; cin = c; start_valid = 1'b1;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      start_valid = 1'b0;
      op_a = $urandom; op_b = $urandom; cin = $urandom_range(0, 1);
      if (res_valid) break;
      if (n <= NBYTES) begin
        obs_a[n-1] = add_a; obs_b[n-1] = add_b; obs_c[n-1] = add_cin;
      end
    end
    checks++;
    if (n != NBYTES + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d edges want %0d", name, n, NBYTES + 1);
    end
    checks++;
    if (sum !== exp[W-1:0]) begin
      errors++;
      $display("FAIL %s sum: got %h want %h", name, sum, exp[W-1:0]);
    end
    checks++;
    if (cout !== exp[W]) begin
      errors++;
      $display("FAIL %s cout: got %b want %b", name, cout, exp[W]);
    end
    checks++;
    if (overflow !== exp[W+1]) begin
      errors++;
      $display("FAIL %s overflow: got %b want %b", name, overflow, exp[W+1]);
    end
    if (release_res) begin
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s release: got valid=%b ready=%b want 0 1", name, res_valid, start_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (res_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got v=%b s=%h c=%b o=%b want 0 0 0 0",
               res_valid, sum, cout, overflow);
    end
    checks++;
    if (start_ready !== 1'b0 || add_a !== 8'h00 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset ready/add: got rdy=%b a=%h ci=%b want 0 00 0", start_ready, add_a, add_cin);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset release start_ready: got %b want 1", start_ready);
    end
  endtask

  task automatic test_directed();
    run_op(32'h00000014, 32'h0000001F, 1'b1, 1'b1, "basic");
    checks++;
    if (obs_a[0] !== 8'h14 || obs_b[0] !== 8'h1F || obs_c[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic byte0 drive: got a=%h b=%h ci=%b want 14 1f 1", obs_a[0], obs_b[0], obs_c[0]);
    end
    checks++;
    if (sum !== 32'h00000034) begin
      errors++;
      $display("FAIL basic const sum: got %h want 00000034", sum);
    end
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b1, "ripple");
    checks++;
    if (obs_c[1] !== 1'b1 || obs_a[1] !== 8'h00 || sum !== 32'h00000100) begin
      errors++;
      $display("FAIL ripple carry: got ci1=%b a1=%h sum=%h want 1 00 00000100", obs_c[1], obs_a[1], sum);
    end
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, "wrap");
    checks++;
    if (sum !== 32'h0 || cout !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap const: got s=%h c=%b o=%b want 0 1 0", sum, cout, overflow);
    end
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, "sovf");
    checks++;
    if (sum !== 32'h80000000 || cout !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL sovf const: got s=%h c=%b o=%b want 80000000 0 1", sum, cout, overflow);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    run_op(32'h01020304, 32'h10203040, 1'b0, 1'b0, "bp_op");
    held = sum;
    for (int i = 0; i < 6; i++) begin
      start_valid = i[0];
      op_a = $urandom; op_b = $urandom;
      step();
      checks++;
      if (sum !== held || start_ready !== 1'b0 || res_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp stall %0d: got s=%h rdy=%b v=%b want %h 0 1", i, sum, start_ready, res_valid, held);
      end
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || sum !== held) begin
      errors++;
      $display("FAIL bp release: got v=%b rdy=%b s=%h want 0 1 %h", res_valid, start_ready, sum, held);
    end
    run_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b1, "bp_next");
  endtask

  task automatic test_reset_mid_run();
    op_a = 32'hDEADBEEF; op_b = 32'h01010101; cin = 1'b0; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (res_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || start_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrun reset: got v=%b s=%h c=%b rdy=%b want 0 0 0 0", res_valid, sum, cout, start_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun ready after reset: got %b want 1", start_ready);
    end
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b1, "after_rst");
    checks++;
    if (sum !== 32'h23456789) begin
      errors++;
      $display("FAIL after_rst const sum: got %h want 23456789", sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] q[$];
    logic [W+1:0] exp;
    int issued, got, cyc, last_cyc;
    issued = 0; got = 0; cyc = 0; last_cyc = -1;
    res_ready = 1'b1;
    start_valid = 1'b1;
    while (got < 1000 && cyc < 20000) begin
      if (start_ready && issued < 1000) begin
        op_a = $urandom; op_b = $urandom; cin = $urandom_range(0, 1);
        q.push_back(ref_add(op_a, op_b, cin));
        issued++;
      end
      step();
      cyc++;
      if (res_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b unexpected result at cycle %0d", cyc);
        end else begin
          exp = q.pop_front();
          if ({overflow, cout, sum} !== exp) begin
            errors++;
            $display("FAIL b2b result %0d: got %h want %h", got, {overflow, cout, sum}, exp);
          end
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != NBYTES + 2) begin
            errors++;
            $display("FAIL b2b interval %0d: got %0d want %0d", got, cyc - last_cyc, NBYTES + 2);
          end
        end
        last_cyc = cyc;
        got++;
      end
    end
    checks++;
    if (got != 1000) begin
      errors++;
      $display("FAIL b2b count: got %0d want 1000", got);
    end
    start_valid = 1'b0;
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
